fetch_unit: RTL and testbench

// - Instruction fetch stage directly upstream of instr_mem.
// - Owns the program counter (PC) and drives instr_mem's byte address.
// - Captures the combinational instruction returned by instr_mem into a small FIFO fetch queue.
// - Presents {pc, instruction} to decode over a valid/ready handshake.
// - Accepts branch/jump redirects from later stages; a redirect flushes the queue.

---
 rtl/fetch_unit.sv | 144 ++++++++++++++
 tb/tb_fetch_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage sitting directly in front of instr_mem.
// Owns the PC, drives the memory address, captures the returned instruction
// into a small FIFO fetch queue and hands {pc, instruction} to decode over a
// valid/ready handshake. A redirect from a later stage flushes the queue and
// reloads the PC.
// Optional build macro: FETCH_PERF_CNT_EN adds the stall_cycles counter/port.
module fetch_unit #(
    parameter int               Isize    = 32,
    parameter int               mem_size = 10,
    parameter int               FQ_DEPTH = 2,
    parameter logic [Isize-1:0] RESET_PC = '0
) (
    input  logic                      clock,
    input  logic                      nReset,
    output logic [Isize-1:0]          address,
    input  logic [Isize-1:0]          instruction,
    input  logic                      redirect_valid,
    input  logic [Isize-1:0]          redirect_pc,
    output logic                      dec_valid,
    input  logic                      dec_ready,
    output logic [Isize-1:0]          dec_instr,
    output logic [Isize-1:0]          dec_pc,
    output logic [$clog2(FQ_DEPTH):0] fq_count
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]               stall_cycles
`endif
);

    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);

    // The pointer arithmetic relies on natural wrap, so the depth must be a
    // power of two; mem_size is carried only for consistency with instr_mem.
    if (FQ_DEPTH < 2 || (FQ_DEPTH & (FQ_DEPTH - 1)) != 0 || mem_size < 1) begin : g_param_check
        $error("fetch_unit: FQ_DEPTH must be a power of two >= 2 and mem_size >= 1");
    end

    logic [Isize-1:0] pc_q,   pc_d;
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q,  cnt_d;

    // Queue storage is pure data: it is never read unless the count says the
    // slot is live, so it carries no reset.
    logic [Isize-1:0] qpc_q    [FQ_DEPTH];
    logic [Isize-1:0] qinstr_q [FQ_DEPTH];

    logic pop;
    logic push;
    logic full;

    // The two alignment bits of a redirect target are deliberately dropped.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign address   = pc_q;
    assign full      = (cnt_q == DEPTH_C);
    assign dec_valid = (cnt_q != '0);
    assign pop       = dec_valid & dec_ready;
    // A full queue can still accept when the head leaves in the same cycle.
    assign push      = ~redirect_valid & (~full | pop);

    // Head of queue goes straight to decode; forced to zero when nothing is
    // live so stale entries never leak out after a flush or reset.
    assign dec_pc    = dec_valid ? qpc_q[rptr_q]    : '0;
    assign dec_instr = dec_valid ? qinstr_q[rptr_q] : '0;
    assign fq_count  = cnt_q;

    // Next-state for PC, pointers and occupancy; redirect overrides everything.
    always_comb begin
        pc_d   = pc_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (redirect_valid) begin
            pc_d   = {redirect_pc[Isize-1:2], 2'b00};
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + PW'(1);
                pc_d   = pc_q + Isize'(4);
            end
            if (pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            if (push && !pop) begin
                cnt_d = cnt_q + CW'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    // Control state: PC, read/write pointers and occupancy.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            pc_q   <= RESET_PC;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            pc_q   <= pc_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Capture the instruction returned for the current PC into the tail slot.
    always_ff @(posedge clock) begin
        if (push) begin
            qpc_q[wptr_q]    <= pc_q;
            qinstr_q[wptr_q] <= instruction;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;

    // Count cycles where fetch is blocked only by decode back-pressure.
    always_comb begin
        stall_d = stall_q;
        if (!redirect_valid && full && !pop && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Stall counter register, saturating.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: scoreboard of expected decode entries fed by a
// behavioural fetch model, with a negedge monitor comparing DUT outputs.
module tb_fetch_unit;

    localparam int FQ_DEPTH = 2;
    localparam int CW       = $clog2(FQ_DEPTH) + 1;

    logic          clock = 1'b0;
    logic          nReset = 1'b0;
    logic [31:0]   address;
    logic [31:0]   instruction;
    logic          redirect_valid = 1'b0;
    logic [31:0]   redirect_pc = '0;
    logic          dec_valid;
    logic          dec_ready = 1'b0;
    logic [31:0]   dec_instr;
    logic [31:0]   dec_pc;
    logic [CW-1:0] fq_count;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]   stall_cycles;
`endif

    fetch_unit #(
        .Isize    (32),
        .mem_size (10),
        .FQ_DEPTH (FQ_DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clock          (clock),
        .nReset         (nReset),
        .address        (address),
        .instruction    (instruction),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .fq_count       (fq_count)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles   (stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    // Instruction memory contents: a fixed scramble of the byte address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign instruction = mem_word(address);

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: expected queue contents {pc, instr}, next PC, stall count.
    logic [63:0] sb[$];
    logic [31:0] m_pc       = '0;
    logic [31:0] m_stall    = '0;
    bit          m_stall_inc = 1'b0;
    bit          active      = 1'b0;

    // Monitor: outputs are stable at negedge; inputs for the coming edge are set.
    always @(negedge clock) begin
        if (active) begin
            check("fq_count", 32'(fq_count), 32'(sb.size()));
            check("address", address, m_pc);
            check("dec_valid", 32'(dec_valid), 32'(sb.size() != 0));
            if (sb.size() != 0) begin
                check("dec_pc", dec_pc, sb[0][63:32]);
                check("dec_instr", dec_instr, sb[0][31:0]);
            end
`ifdef FETCH_PERF_CNT_EN
            check("stall_cycles", stall_cycles, m_stall);
`endif
            m_stall_inc = (sb.size() == FQ_DEPTH) && !dec_ready && !redirect_valid;
            if (sb.size() != 0 && dec_ready) void'(sb.pop_front());
        end
    end

    // Advance the model by the edge that just happened (pop already taken by the monitor).
    task automatic model_update(input bit rv, input logic [31:0] rpc);
        if (m_stall_inc && m_stall != 32'hFFFF_FFFF) m_stall++;
        m_stall_inc = 1'b0;
        if (rv) begin
            sb.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else if (sb.size() < FQ_DEPTH) begin
            sb.push_back({m_pc, mem_word(m_pc)});
            m_pc += 32'd4;
        end
    endtask

    task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc);
        dec_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clock);
        #1;
        model_update(rv, rpc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_address"}, address, 32'h0);
        check({tag, "_dec_valid"}, 32'(dec_valid), 32'h0);
        check({tag, "_dec_pc"}, dec_pc, 32'h0);
        check({tag, "_dec_instr"}, dec_instr, 32'h0);
        check({tag, "_fq_count"}, 32'(fq_count), 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check({tag, "_stall"}, stall_cycles, 32'h0);
`endif
    endtask

    task automatic model_reset();
        sb.delete();
        m_pc        = '0;
        m_stall     = '0;
        m_stall_inc = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        nReset = 1'b1;
        model_reset();
        active = 1'b1;

        // T1: free-running fetch from reset
        repeat (3) step(1'b1, 1'b0, '0);
        // T2: back-pressure fills the queue, then drain without bubbles
        repeat (5) step(1'b0, 1'b0, '0);
        repeat (3) step(1'b1, 1'b0, '0);
        // T3: redirect with a full queue
        step(1'b0, 1'b1, 32'h20);
        repeat (3) step(1'b1, 1'b0, '0);
        // T4: misaligned redirect target
        step(1'b1, 1'b1, 32'h13);
        repeat (3) step(1'b1, 1'b0, '0);
        // T5: PC wrap at the top of the address space
        step(1'b1, 1'b1, 32'hFFFF_FFFC);
        repeat (4) step(1'b1, 1'b0, '0);
        // Back-to-back redirects, last one wins
        step(1'b1, 1'b1, 32'h100);
        step(1'b1, 1'b1, 32'h204);
        repeat (3) step(1'b1, 1'b0, '0);
        // T6: long stall with a full queue
        repeat (9) step(1'b0, 1'b0, '0);

        // Asynchronous reset mid-stream, checked before the next clock edge
        active = 1'b0;
        nReset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        #1;
        nReset = 1'b1;
        model_reset();
        active = 1'b1;

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            bit          rdy;
            bit          rv;
            logic [31:0] rpc;
            rdy = ($urandom_range(0, 9) < 7);
            rv  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else rpc = $urandom;
            step(rdy, rv, rpc);
        end

        @(negedge clock);
        active = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
